mem_arbiter_16: RTL

- Shares one single-port 16-bit unified memory between the instruction-fetch port and the load/store port of the 16-bit MIPS core.
- Grants one access per cycle using round-robin arbitration, and returns read data through a fixed-latency tag pipeline.
- Sits between the core (fetch and data ports) and the memory macro.
- The core uses the deasserted grant as its stall condition.

---
 rtl/mem_arbiter_16_pkg.sv | 15 +
 rtl/mem_arbiter_16_resp_tag_pipe.sv | 33 +++
 rtl/mem_arbiter_16.sv | 82 ++++++++
 3 files changed

// File: rtl/mem_arbiter_16_pkg.sv
// rtl/mem_arbiter_16_pkg.sv - shared port ids, response tag type and latency limits
package mem_arbiter_16_pkg;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef struct packed {
        logic valid;
        logic port;
    } resp_tag_t;

endpackage

// File: rtl/mem_arbiter_16_resp_tag_pipe.sv
// rtl/mem_arbiter_16_resp_tag_pipe.sv - RD_LAT-deep shift register of read-response tags
module resp_tag_pipe
    import mem_arbiter_16_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_port,
    output logic o_valid,
    output logic o_port
);

    resp_tag_t r_stage [RD_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= '{valid: i_valid, port: i_port};
            for (int i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_stage[RD_LAT-1].valid;
    assign o_port  = r_stage[RD_LAT-1].port;

endmodule

// File: rtl/mem_arbiter_16.sv
// rtl/mem_arbiter_16.sv - round-robin fetch/data arbiter for a shared single-port memory
module mem_arbiter_16
    import mem_arbiter_16_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   conflict_cnt
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_arbiter_16: RD_LAT out of range");
    end

    logic        r_last_d;
    logic [15:0] r_conflict_cnt;
    logic        w_contest;
    logic        w_d_win;
    logic        w_if_win;
    logic        w_tag_valid;
    logic        w_tag_port;

    // Data wins a contest only when fetch won the previous one.
    assign w_contest = if_req & d_req;
    assign w_d_win   = ~reset & d_req & (~if_req | ~r_last_d);
    assign w_if_win  = ~reset & if_req & ~w_d_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d       <= 1'b0;
            r_conflict_cnt <= 16'h0000;
        end else if (w_contest) begin
            r_last_d <= w_d_win;
            if (r_conflict_cnt != 16'hFFFF) begin
                r_conflict_cnt <= r_conflict_cnt + 16'h0001;
            end
        end
    end

    assign if_gnt       = w_if_win;
    assign d_gnt        = w_d_win;
    assign mem_en       = w_if_win | w_d_win;
    assign mem_we       = w_d_win & d_we;
    assign mem_addr     = w_d_win ? d_addr : if_addr;
    assign mem_wdata    = w_d_win ? d_wdata : '0;
    assign conflict_cnt = r_conflict_cnt;

    resp_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (mem_en & ~mem_we),
        .i_port  (w_d_win ? PORT_D : PORT_IF),
        .o_valid (w_tag_valid),
        .o_port  (w_tag_port)
    );

    assign if_rvalid = ~reset & w_tag_valid & (w_tag_port == PORT_IF);
    assign d_rvalid  = ~reset & w_tag_valid & (w_tag_port == PORT_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
